// File: rtl/fetch_queue_pkg.sv
// Shared widths and FSM encodings for the instruction fetch front end.
package fetch_queue_pkg;

  localparam int FQ_WORD_SIZE  = 32;
  localparam int FQ_BLOCK_SIZE = 256;
  localparam int FQ_BYTE_SIZE  = 8;

  // Fetch sequencer states: REQ presents the address, CAP captures the block,
  // HOLD waits until the queue has room for a whole block.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_CAP  = 2'd1,
    ST_HOLD = 2'd2
  } fq_state_e;

  // Free entries remaining after this cycle's count update.
  function automatic int unsigned fq_room(input int unsigned depth,
                                          input int unsigned count_next);
    return depth - count_next;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Circular buffer of {pc, inst} entries with a block-wide parallel write
// port and a single read port. Flush empties it without touching storage.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int WORD_SIZE = FQ_WORD_SIZE,
  parameter int WPB       = 8,
  parameter int DEPTH     = 16,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WPB*WORD_SIZE-1:0] wr_inst_i,
  input  logic [WPB*WORD_SIZE-1:0] wr_pc_i,
  input  logic                     rd_en_i,
  output logic [WORD_SIZE-1:0]     rd_inst_o,
  output logic [WORD_SIZE-1:0]     rd_pc_o,
  output logic [CNT_W-1:0]         count_o,
  output logic [CNT_W-1:0]         count_next_o
);

  logic [WORD_SIZE-1:0] inst_mem_q [DEPTH];
  logic [WORD_SIZE-1:0] pc_mem_q   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy update; flush overrides any write or read.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_W'(WPB);
      if (rd_en_i) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (wr_en_i ? CNT_W'(WPB) : CNT_W'(0))
                        - (rd_en_i ? CNT_W'(1)   : CNT_W'(0));
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: cleared on reset so nothing stale is ever visible at the head;
  // a flushed write never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (wr_en_i && !flush_i) begin
      for (int k = 0; k < WPB; k++) begin
        inst_mem_q[wr_ptr_q + PTR_W'(k)] <= wr_inst_i[k*WORD_SIZE +: WORD_SIZE];
        pc_mem_q[wr_ptr_q + PTR_W'(k)]   <= wr_pc_i[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  assign rd_inst_o    = inst_mem_q[rd_ptr_q];
  assign rd_pc_o      = pc_mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, requests cache blocks, unpacks them
// into the word queue and hands words to decode; redirects flush and refetch.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int WORD_SIZE  = FQ_WORD_SIZE,
  parameter int BLOCK_SIZE = FQ_BLOCK_SIZE,
  parameter int DEPTH      = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [WORD_SIZE-1:0]  cache_addr,
  input  logic [BLOCK_SIZE-1:0] cache_block,
  input  logic                  redirect_valid,
  input  logic [WORD_SIZE-1:0]  redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [WORD_SIZE-1:0]  inst,
  output logic [WORD_SIZE-1:0]  inst_pc
);

  localparam int WPB         = BLOCK_SIZE / WORD_SIZE;
  localparam int WORD_BYTES  = WORD_SIZE / FQ_BYTE_SIZE;
  localparam int BLOCK_BYTES = BLOCK_SIZE / FQ_BYTE_SIZE;
  localparam int CNT_W       = $clog2(DEPTH) + 1;

  fq_state_e            state_q, state_d;
  logic [WORD_SIZE-1:0] fetch_pc_q, fetch_pc_d;

  logic                     capture;
  logic                     pop;
  logic                     room_ok;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         count_next;
  logic [WPB*WORD_SIZE-1:0] wr_inst;
  logic [WPB*WORD_SIZE-1:0] wr_pc;

  // A redirect kills both the capture and the pop of its own cycle.
  assign pop        = inst_valid && inst_ready && !redirect_valid;
  assign inst_valid = (count != '0);
  assign cache_addr = fetch_pc_q;
  assign room_ok    = fq_room(DEPTH, 32'(count_next)) >= WPB;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_REQ;
    else        state_q <= state_d;
  end

  // FSM next state: request, capture, then throttle until a block fits.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = ST_REQ;
    end else begin
      unique case (state_q)
        ST_REQ:  state_d = ST_CAP;
        ST_CAP:  state_d = room_ok ? ST_REQ : ST_HOLD;
        ST_HOLD: state_d = room_ok ? ST_REQ : ST_HOLD;
        default: state_d = ST_REQ;
      endcase
    end
  end

  // FSM outputs: the cache block is only written during CAP.
  always_comb begin
    capture = (state_q == ST_CAP) && !redirect_valid;
  end

  // Fetch PC advances one block per capture; a redirect reloads it.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (capture)    fetch_pc_d = fetch_pc_q + WORD_SIZE'(BLOCK_BYTES);
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_pc_q <= RESET_PC;
    else        fetch_pc_q <= fetch_pc_d;
  end

  // Unpack the block MSB-first into words with their byte addresses; the
  // cache returns the shifted window, so this holds for unaligned PCs too.
  always_comb begin
    wr_inst = '0;
    wr_pc   = '0;
    for (int k = 0; k < WPB; k++) begin
      wr_inst[k*WORD_SIZE +: WORD_SIZE] = cache_block[BLOCK_SIZE-1-k*WORD_SIZE -: WORD_SIZE];
      wr_pc[k*WORD_SIZE +: WORD_SIZE]   = fetch_pc_q + WORD_SIZE'(k * WORD_BYTES);
    end
  end

  fetch_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .WPB       (WPB),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .wr_en_i      (capture),
    .wr_inst_i    (wr_inst),
    .wr_pc_i      (wr_pc),
    .rd_en_i      (pop),
    .rd_inst_o    (inst),
    .rd_pc_o      (inst_pc),
    .count_o      (count),
    .count_next_o (count_next)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle table for the reset sequence,
// scoreboard of the expected word stream, hand sequences for corner cases.
module tb_fetch_queue;

  localparam int W     = 32;
  localparam int BS    = 256;
  localparam int DEPTH = 16;
  localparam int WPB   = BS / W;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  cache_addr;
  logic [BS-1:0] cache_block;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [W-1:0]  inst;
  logic [W-1:0]  inst_pc;

  fetch_queue #(
    .WORD_SIZE  (W),
    .BLOCK_SIZE (BS),
    .DEPTH      (DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cache_addr     (cache_addr),
    .cache_block    (cache_block),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory image: the word at byte address a.
  function automatic logic [W-1:0] word_at(input logic [W-1:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  // Cache model: block for the address presented last cycle, first byte at MSB.
  logic [W-1:0] addr_lat;
  always @(posedge clk) addr_lat <= cache_addr;
  always_comb begin
    cache_block = '0;
    for (int k = 0; k < WPB; k++)
      cache_block[BS-1-k*W -: W] = word_at(addr_lat + 32'(4*k));
  end

  typedef struct { logic [W-1:0] inst; logic [W-1:0] pc; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic         ready;
    logic         exp_valid;
    logic [W-1:0] exp_inst;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_addr;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word stream starting at pc.
  task automatic sb_start(input logic [W-1:0] pc);
    exp_t e;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc   = pc + 32'(4*i);
      e.inst = word_at(e.pc);
      sb.push_back(e);
    end
  endtask

  // Drive one cycle's inputs, score the pop it causes, advance to next negedge.
  task automatic step(input logic rdy, input logic rv = 1'b0, input logic [W-1:0] rpc = '0);
    exp_t e;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (rv) begin
      sb_start(rpc);
    end else if (inst_valid && rdy) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got pc %h expected no word", inst_pc);
      end else begin
        e = sb.pop_front();
        chk("pop_inst", inst, e.inst);
        chk("pop_pc", inst_pc, e.pc);
      end
    end
    @(negedge clk);
  endtask

  // Hold reset two cycles, check reset outputs, release at a negedge.
  task automatic do_reset();
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_addr", cache_addr, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    sb_start(32'h0);
    rst_n = 1'b1;
  endtask

  // Writing a block into a queue without room for it must never happen.
  always @(negedge clk) begin
    if (rst_n && dut.capture && (int'(dut.u_fifo.count_o) > DEPTH - WPB)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL overflow: count %0d at capture, limit %0d", dut.u_fifo.count_o, DEPTH - WPB);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{1'b1, 1'b0, 32'h0, 32'h00, 32'h00},
      '{1'b1, 1'b0, 32'h0, 32'h00, 32'h00},
      '{1'b1, 1'b1, 32'h1, 32'h00, 32'h20},
      '{1'b1, 1'b1, 32'h2, 32'h04, 32'h20},
      '{1'b1, 1'b1, 32'h3, 32'h08, 32'h40},
      '{1'b1, 1'b1, 32'h4, 32'h0C, 32'h40},
      '{1'b1, 1'b1, 32'h5, 32'h10, 32'h40},
      '{1'b1, 1'b1, 32'h6, 32'h14, 32'h40},
      '{1'b1, 1'b1, 32'h7, 32'h18, 32'h40},
      '{1'b1, 1'b1, 32'h8, 32'h1C, 32'h40},
      '{1'b1, 1'b1, 32'h9, 32'h20, 32'h40},
      '{1'b1, 1'b1, 32'hA, 32'h24, 32'h40}
    };

    // Reset to first instruction, free-running decode.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      chk("t1_valid", inst_valid, vecs[c].exp_valid);
      chk("t1_addr", cache_addr, vecs[c].exp_addr);
      if (vecs[c].exp_valid) begin
        chk("t1_inst", inst, vecs[c].exp_inst);
        chk("t1_pc", inst_pc, vecs[c].exp_pc);
      end
      step(vecs[c].ready);
    end

    // Stalled decode fills the queue and parks in HOLD.
    do_reset();
    repeat (10) step(1'b0);
    chk("t2_full_addr", cache_addr, 32'h40);
    chk("t2_full_count", 32'(dut.u_fifo.count_o), 32'd16);
    chk("t2_full_valid", inst_valid, 1'b1);
    chk("t2_head_pc", inst_pc, 32'h0);
    repeat (8) step(1'b1);
    chk("t2_drain_count", 32'(dut.u_fifo.count_o), 32'd8);
    step(1'b0);
    step(1'b1);
    chk("t2_cap_pop_count", 32'(dut.u_fifo.count_o), 32'd15);
    chk("t2_cap_addr", cache_addr, 32'h60);

    // Redirect while the first block is being captured.
    do_reset();
    step(1'b1);
    step(1'b1, 1'b1, 32'h1004);
    chk("t3_flush_valid", inst_valid, 1'b0);
    chk("t3_flush_count", 32'(dut.u_fifo.count_o), 32'd0);
    chk("t3_req_addr", cache_addr, 32'h1004);
    step(1'b1);
    chk("t3_cap_valid", inst_valid, 1'b0);
    step(1'b1);
    chk("t3_new_valid", inst_valid, 1'b1);
    chk("t3_new_pc", inst_pc, 32'h1004);
    chk("t3_new_inst", inst, word_at(32'h1004));
    repeat (4) step(1'b1);

    // Unaligned redirect from a running stream.
    step(1'b1, 1'b1, 32'h0000000C);
    chk("t4_flush_valid", inst_valid, 1'b0);
    step(1'b1);
    step(1'b1);
    chk("t4_valid", inst_valid, 1'b1);
    chk("t4_pc", inst_pc, 32'hC);
    chk("t4_next_addr", cache_addr, 32'h2C);
    repeat (8) step(1'b1);

    // Short asynchronous reset pulse with a partly full queue.
    do_reset();
    repeat (6) step(1'b1);
    chk("t5_count_before", 32'(dut.u_fifo.count_o), 32'd12);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", inst_valid, 1'b0);
    chk("t5_async_addr", cache_addr, 32'h0);
    chk("t5_async_inst", inst, 32'h0);
    chk("t5_async_pc", inst_pc, 32'h0);
    #1 rst_n = 1'b1;
    sb_start(32'h0);
    @(negedge clk);
    chk("t5_restart_cap", inst_valid, 1'b0);
    step(1'b1);
    chk("t5_restart_valid", inst_valid, 1'b1);
    chk("t5_restart_pc", inst_pc, 32'h0);
    chk("t5_restart_inst", inst, 32'h1);
    repeat (8) step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
